hazard_scoreboard_unit: RTL and testbench

Parametrised scoreboard-based hazard detection and forwarding unit for the phoeniX pipeline. It sits beside the decode stage. It tracks in-flight register writes with per-register busy bits and latency countdowns, and raises a decode stall on RAW or WAW hazards. It drives operand forwarding selects from the EX/MEM and MEM/WB stage registers. It replaces the combinational-only hazard check with multi-cycle latency awareness (loads, multi-cycle ALU ops), a no-forwarding mode and a stall performance counter.

---
 rtl/hazard_scoreboard_unit.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard unit: per-register busy/countdown tracking,
// RAW/WAW decode stall, operand forwarding selects and stall counter.
module hazard_scoreboard_unit #(
  parameter int REG_COUNT         = 32,
  parameter int ADDR_WIDTH        = 5,
  parameter int LAT_WIDTH         = 4,
  parameter bit FORWARDING_ENABLE = 1'b1,
  parameter int STALL_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rs1,
  input  logic [ADDR_WIDTH-1:0]      issue_rs2,
  input  logic                       issue_rs1_used,
  input  logic                       issue_rs2_used,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  input  logic                       issue_rd_write,
  input  logic [LAT_WIDTH-1:0]       issue_latency,
  input  logic [ADDR_WIDTH-1:0]      exmem_rd,
  input  logic [ADDR_WIDTH-1:0]      memwb_rd,
  input  logic                       exmem_write,
  input  logic                       memwb_write,
  input  logic                       wb_valid,
  input  logic [ADDR_WIDTH-1:0]      wb_rd,
  output logic                       stall,
  output logic [1:0]                 forward_rs1,
  output logic [1:0]                 forward_rs2,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  logic [REG_COUNT-1:0] busy;
  logic [LAT_WIDTH-1:0] remaining [REG_COUNT];

  logic [LAT_WIDTH-1:0] lat_eff;
  logic                 raw;
  logic                 waw;
  logic                 accept;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] r);
    return (r != '0) && (32'(r) < REG_COUNT);
  endfunction

  function automatic logic not_ready(input logic [ADDR_WIDTH-1:0] r);
    logic nr;
    nr = 1'b0;
    if (in_range(r)) begin
      if (FORWARDING_ENABLE)
        nr = busy[r] && (remaining[r] != '0);
      else
        nr = busy[r];
    end
    return nr;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (FORWARDING_ENABLE && src != '0) begin
      if (exmem_write && exmem_rd == src)
        sel = 2'b01;
      else if (memwb_write && memwb_rd == src)
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Countdown holds cycles beyond the next one, so latency 1
  // results are forwardable to the very next instruction.
  always_comb begin
    lat_eff = (issue_latency == '0) ? LAT_WIDTH'(1) : issue_latency;
    raw = (issue_rs1_used && not_ready(issue_rs1))
       || (issue_rs2_used && not_ready(issue_rs2));
    waw = 1'b0;
    if (issue_rd_write && in_range(issue_rd))
      waw = busy[issue_rd] && (remaining[issue_rd] >= lat_eff);
    stall  = issue_valid && (raw || waw);
    accept = issue_valid && !stall && issue_rd_write
          && in_range(issue_rd);
    forward_rs1 = fwd_sel(issue_rs1);
    forward_rs2 = fwd_sel(issue_rs2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        remaining[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (accept && 32'(issue_rd) == i) begin
          busy[i]      <= 1'b1;
          remaining[i] <= lat_eff - LAT_WIDTH'(1);
        end else if (wb_valid && wb_rd != '0 && 32'(wb_rd) == i) begin
          busy[i]      <= 1'b0;
          remaining[i] <= '0;
        end else if (remaining[i] != '0) begin
          remaining[i] <= remaining[i] - LAT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: forwarding build
// and a no-forwarding build with a 2-bit stall counter.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_rs1_used, issue_rs2_used, issue_rd_write;
  logic [3:0] issue_latency;
  logic [4:0] exmem_rd, memwb_rd, wb_rd;
  logic       exmem_write, memwb_write, wb_valid;

  logic        stall_a, stall_b;
  logic [1:0]  fwd1_a, fwd2_a, fwd1_b, fwd2_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut_a (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .issue_latency(issue_latency),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall_a), .forward_rs1(fwd1_a), .forward_rs2(fwd2_a),
    .stall_cycles(cnt_a)
  );

  hazard_scoreboard_unit #(
    .FORWARDING_ENABLE(1'b0),
    .STALL_CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .issue_latency(issue_latency),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall_b), .forward_rs1(fwd1_b), .forward_rs2(fwd2_b),
    .stall_cycles(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_rs1      = '0;
    issue_rs2      = '0;
    issue_rd       = '0;
    issue_rs1_used = 1'b0;
    issue_rs2_used = 1'b0;
    issue_rd_write = 1'b0;
    issue_latency  = '0;
    exmem_rd       = '0;
    memwb_rd       = '0;
    exmem_write    = 1'b0;
    memwb_write    = 1'b0;
    wb_valid       = 1'b0;
    wb_rd          = '0;
  endtask

  task automatic produce(input logic [4:0] rd, input logic [3:0] lat);
    idle();
    issue_valid    = 1'b1;
    issue_rd       = rd;
    issue_rd_write = 1'b1;
    issue_latency  = lat;
  endtask

  task automatic consume(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
    idle();
    issue_valid    = 1'b1;
    issue_rs1      = rs1;
    issue_rs1_used = u1;
    issue_rs2      = rs2;
    issue_rs2_used = u2;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check("rst_stall", 32'(stall_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_fwd1", 32'(fwd1_a), 0);
    @(negedge clk);
    reset = 1'b0;

    // reset in the middle of a stall
    produce(5'd5, 4'd3);
    #1;
    check("prod5_nostall", 32'(stall_a), 0);
    tick();
    consume(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check("dep5_stall", 32'(stall_a), 1);
    tick();
    check("dep5_cnt", 32'(cnt_a), 1);
    reset = 1'b1;
    #1;
    check("midrst_stall", 32'(stall_a), 0);
    check("midrst_cnt", 32'(cnt_a), 0);
    reset = 1'b0;
    tick();
    check("postrst_stall", 32'(stall_a), 0);

    // ALU result forwarded from EX/MEM
    produce(5'd3, 4'd1);
    tick();
    consume(5'd3, 1'b1, 5'd0, 1'b0);
    exmem_rd    = 5'd3;
    exmem_write = 1'b1;
    #1;
    check("alu_stall", 32'(stall_a), 0);
    check("alu_fwd1", 32'(fwd1_a), 1);
    check("alu_fwd2", 32'(fwd2_a), 0);
    tick();

    // load-use: exactly one bubble
    produce(5'd7, 4'd2);
    #1;
    check("ld_nostall", 32'(stall_a), 0);
    tick();
    consume(5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    check("ld_use_stall", 32'(stall_a), 1);
    tick();
    check("ld_use_go", 32'(stall_a), 0);
    check("ld_use_cnt", 32'(cnt_a), 1);
    tick();

    // WAW against a long in-flight write to x4
    produce(5'd4, 4'd5);
    tick();
    produce(5'd4, 4'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("waw_stall%0d", i), 32'(stall_a), 1);
      tick();
    end
    check("waw_go", 32'(stall_a), 0);
    check("waw_cnt", 32'(cnt_a), 5);
    // accept and writeback to x4 on the same edge
    issue_latency = 4'd2;
    wb_valid      = 1'b1;
    wb_rd         = 5'd4;
    #1;
    check("acc_wb_go", 32'(stall_a), 0);
    tick();
    consume(5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    check("acc_wins_stall", 32'(stall_a), 1);
    tick();
    check("acc_wins_go", 32'(stall_a), 0);
    check("acc_wins_cnt", 32'(cnt_a), 6);
    tick();

    // x0 and forwarding priority
    consume(5'd0, 1'b1, 5'd0, 1'b1);
    exmem_rd    = 5'd0;
    exmem_write = 1'b1;
    #1;
    check("x0_fwd1", 32'(fwd1_a), 0);
    check("x0_stall", 32'(stall_a), 0);
    consume(5'd9, 1'b1, 5'd9, 1'b0);
    exmem_rd    = 5'd9;
    memwb_rd    = 5'd9;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    #1;
    check("prio_fwd1", 32'(fwd1_a), 1);
    exmem_rd = 5'd1;
    #1;
    check("memwb_fwd1", 32'(fwd1_a), 2);
    check("memwb_fwd2", 32'(fwd2_a), 2);
    tick();

    // zero latency behaves as ALU latency
    produce(5'd10, 4'd0);
    tick();
    consume(5'd10, 1'b1, 5'd0, 1'b0);
    #1;
    check("lat0_stall", 32'(stall_a), 0);
    check("lat0_cnt", 32'(cnt_a), 6);
    tick();

    // no-forwarding build with saturating 2-bit counter
    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("b_rst_cnt", 32'(cnt_b), 0);
    produce(5'd6, 4'd1);
    #1;
    check("b_prod_go", 32'(stall_b), 0);
    tick();
    consume(5'd6, 1'b1, 5'd0, 1'b0);
    exmem_rd    = 5'd6;
    exmem_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("b_stall%0d", i), 32'(stall_b), 1);
      check($sformatf("b_fwd%0d", i), 32'(fwd1_b), 0);
      tick();
    end
    check("b_cnt_sat", 32'(cnt_b), 3);
    wb_valid = 1'b1;
    wb_rd    = 5'd6;
    #1;
    check("b_wb_cycle", 32'(stall_b), 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("b_after_wb", 32'(stall_b), 0);
    check("b_cnt_hold", 32'(cnt_b), 3);
    tick();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
